// File: rtl/unique_window_pkg.sv
// unique_window_pkg: shared widths, defaults and reset constants for the
// unique_window tracker and its match sub-module.
package unique_window_pkg;

    // Default geometry of the window.
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    // Reset value of every single-bit flag and pulse.
    localparam logic RST_FLAG = 1'b0;

    // Slot array of the default geometry; slot k occupies bits [k*DATA_W +: DATA_W].
    typedef logic [DEF_DEPTH-1:0][DEF_DATA_W-1:0] window_t;

    // Ceiling log2 with a floor of 1 so a width is never zero.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Width needed to index DEPTH slots.
    function automatic int idx_width(input int depth);
        return clog2_min1(depth);
    endfunction

    // Width needed to hold an occupancy of 0..DEPTH.
    function automatic int cnt_width(input int depth);
        return clog2_min1(depth + 1);
    endfunction

endpackage

// File: rtl/unique_window_match.sv
// unique_window_match: combinational DEPTH-way comparator of one sample
// against the occupied window slots. Empty slots are masked out so a stale
// zero never produces a match. The index comes from a lowest-index priority
// encoder even though the window holds distinct values.
module unique_window_match
    import unique_window_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = idx_width(DEPTH)
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] window,
    input  logic [DEPTH-1:0]             valid,
    input  logic [DATA_W-1:0]            data,
    output logic                         hit,
    output logic [IDX_W-1:0]             idx
);

    // Compare all occupied slots; scan high to low so the lowest match wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid[k] && (window[k] == data)) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/unique_window.sv
// unique_window: tracks the last DEPTH distinct values of a valid-qualified
// stream. A miss shifts the window and inserts at slot 0 (evicting slot
// DEPTH-1 when full); a hit raises a one-cycle pulse with the slot index.
// Optional feature macro: UNIQ_MRU_EN -- when defined, a hit moves the matched
// value to slot 0 (recency order); otherwise hits leave the window untouched.
// Handshake: a sample is taken on every rising edge where in_valid is high;
// there is no backpressure, so the block accepts one sample per cycle.
module unique_window
    import unique_window_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = idx_width(DEPTH),
    parameter int CNT_W  = cnt_width(DEPTH)
) (
    input  logic                      clk_in,
    input  logic                      reset_n_in,
    input  logic                      clear_in,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         data_in,
    output logic [DEPTH*DATA_W-1:0]   out_data,
    output logic [DEPTH-1:0]          out_valid,
    output logic [CNT_W-1:0]          count_out,
    output logic                      new_out,
    output logic                      hit_out,
    output logic [IDX_W-1:0]          hit_idx_out,
    output logic                      evict_valid_out,
    output logic [DATA_W-1:0]         evict_data_out
);

    logic [DEPTH-1:0][DATA_W-1:0] slots_q, slots_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         new_d, hit_d, evict_valid_d;
    logic [IDX_W-1:0]             hit_idx_d;
    logic [DATA_W-1:0]            evict_data_d;

    logic                         match_hit;
    logic [IDX_W-1:0]             match_idx;

    unique_window_match #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_match (
        .window (slots_q),
        .valid  (valid_q),
        .data   (data_in),
        .hit    (match_hit),
        .idx    (match_idx)
    );

    // Next window state and event pulses for the current sample.
    always_comb begin
        slots_d       = slots_q;
        valid_d       = valid_q;
        count_d       = count_q;
        new_d         = 1'b0;
        hit_d         = 1'b0;
        hit_idx_d     = '0;
        evict_valid_d = 1'b0;
        evict_data_d  = '0;
        if (clear_in) begin
            slots_d = '0;
            valid_d = '0;
            count_d = '0;
        end else if (in_valid) begin
            if (match_hit) begin
                hit_d     = 1'b1;
                hit_idx_d = match_idx;
`ifdef UNIQ_MRU_EN
                // Slots above the match keep their place; those below slide up one.
                for (int j = 1; j < DEPTH; j++) begin
                    if (IDX_W'(j) <= match_idx) begin
                        slots_d[j] = slots_q[j-1];
                    end
                end
                slots_d[0] = data_in;
`endif
            end else begin
                new_d = 1'b1;
                slots_d = {slots_q[DEPTH-2:0], data_in};
                valid_d = {valid_q[DEPTH-2:0], 1'b1};
                if (count_q != CNT_W'(DEPTH)) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (valid_q[DEPTH-1]) begin
                    evict_valid_d = 1'b1;
                    evict_data_d  = slots_q[DEPTH-1];
                end
            end
        end
    end

    // Register window state and pulses; reset clears everything asynchronously.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            slots_q         <= '0;
            valid_q         <= '0;
            count_q         <= '0;
            new_out         <= RST_FLAG;
            hit_out         <= RST_FLAG;
            hit_idx_out     <= '0;
            evict_valid_out <= RST_FLAG;
            evict_data_out  <= '0;
        end else begin
            slots_q         <= slots_d;
            valid_q         <= valid_d;
            count_q         <= count_d;
            new_out         <= new_d;
            hit_out         <= hit_d;
            hit_idx_out     <= hit_idx_d;
            evict_valid_out <= evict_valid_d;
            evict_data_out  <= evict_data_d;
        end
    end

    assign out_data  = slots_q;
    assign out_valid = valid_q;
    assign count_out = count_q;

endmodule

// File: tb/tb_unique_window.sv
// tb_unique_window: directed checks of unique_window at DATA_W=8, DEPTH=4.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_unique_window;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 3;

    logic                    clk_in;
    logic                    reset_n_in;
    logic                    clear_in;
    logic                    in_valid;
    logic [DATA_W-1:0]       data_in;
    logic [DEPTH*DATA_W-1:0] out_data;
    logic [DEPTH-1:0]        out_valid;
    logic [CNT_W-1:0]        count_out;
    logic                    new_out;
    logic                    hit_out;
    logic [IDX_W-1:0]        hit_idx_out;
    logic                    evict_valid_out;
    logic [DATA_W-1:0]       evict_data_out;

    int vec_cnt;
    int err_cnt;

    unique_window #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_in          (clk_in),
        .reset_n_in      (reset_n_in),
        .clear_in        (clear_in),
        .in_valid        (in_valid),
        .data_in         (data_in),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .count_out       (count_out),
        .new_out         (new_out),
        .hit_out         (hit_out),
        .hit_idx_out     (hit_idx_out),
        .evict_valid_out (evict_valid_out),
        .evict_data_out  (evict_data_out)
    );

    // Clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog expired");
    end

    // Drivers
    task automatic drive_sample(input logic [DATA_W-1:0] d);
        @(negedge clk_in);
        in_valid = 1'b1;
        data_in  = d;
        @(posedge clk_in);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_clear();
        @(negedge clk_in);
        clear_in = 1'b1;
        @(posedge clk_in);
        #1;
        clear_in = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk_in);
        in_valid = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset_n_in = 1'b0;
        clear_in   = 1'b0;
        in_valid   = 1'b0;
        data_in    = '0;
        #23;
        vec_cnt++;
        if ({out_data, out_valid, count_out, new_out, hit_out, hit_idx_out,
             evict_valid_out, evict_data_out} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got data=%h valid=%b count=%0d new=%b hit=%b idx=%0d ev=%b evd=%h, required all 0",
                     out_data, out_valid, count_out, new_out, hit_out, hit_idx_out,
                     evict_valid_out, evict_data_out);
        end
        @(negedge clk_in);
        reset_n_in = 1'b1;
    endtask

    task automatic test_zero_insert();
        drive_sample(8'h00);
        vec_cnt++;
        if ({new_out, hit_out, out_valid, count_out, out_data} !== {1'b1, 1'b0, 4'b0001, 3'd1, 32'h0}) begin
            err_cnt++;
            $display("FAIL zero_insert: got new=%b hit=%b valid=%b count=%0d data=%h, required new=1 hit=0 valid=0001 count=1 data=00000000",
                     new_out, hit_out, out_valid, count_out, out_data);
        end
        drive_sample(8'h00);
        vec_cnt++;
        if ({hit_out, hit_idx_out, new_out, count_out} !== {1'b1, 2'd0, 1'b0, 3'd1}) begin
            err_cnt++;
            $display("FAIL zero_rehit: got hit=%b idx=%0d new=%b count=%0d, required hit=1 idx=0 new=0 count=1",
                     hit_out, hit_idx_out, new_out, count_out);
        end
    endtask

    task automatic test_fill_evict();
        drive_clear();
        drive_sample(8'h11);
        drive_sample(8'h22);
        drive_sample(8'h33);
        drive_sample(8'h44);
        vec_cnt++;
        if ({evict_valid_out, count_out, out_valid, out_data} !== {1'b0, 3'd4, 4'b1111, 32'h11223344}) begin
            err_cnt++;
            $display("FAIL fill_full: got ev=%b count=%0d valid=%b data=%h, required ev=0 count=4 valid=1111 data=11223344",
                     evict_valid_out, count_out, out_valid, out_data);
        end
        drive_sample(8'h55);
        vec_cnt++;
        if ({new_out, evict_valid_out, evict_data_out, count_out, out_data} !==
            {1'b1, 1'b1, 8'h11, 3'd4, 32'h22334455}) begin
            err_cnt++;
            $display("FAIL evict: got new=%b ev=%b evd=%h count=%0d data=%h, required new=1 ev=1 evd=11 count=4 data=22334455",
                     new_out, evict_valid_out, evict_data_out, count_out, out_data);
        end
        idle_cycle();
        vec_cnt++;
        if ({new_out, evict_valid_out, evict_data_out, count_out} !== {1'b0, 1'b0, 8'h00, 3'd4}) begin
            err_cnt++;
            $display("FAIL evict_pulse_drop: got new=%b ev=%b evd=%h count=%0d, required new=0 ev=0 evd=00 count=4",
                     new_out, evict_valid_out, evict_data_out, count_out);
        end
    endtask

    task automatic test_hit();
        logic [31:0] exp_data;
        logic [1:0]  exp_idx2;
        drive_clear();
        drive_sample(8'h11);
        drive_sample(8'h22);
        drive_sample(8'h33);
        drive_sample(8'h11);
`ifdef UNIQ_MRU_EN
        exp_data = 32'h00223311;
        exp_idx2 = 2'd0;
`else
        exp_data = 32'h00112233;
        exp_idx2 = 2'd2;
`endif
        vec_cnt++;
        if ({hit_out, hit_idx_out, new_out, evict_valid_out, count_out, out_valid, out_data} !==
            {1'b1, 2'd2, 1'b0, 1'b0, 3'd3, 4'b0111, exp_data}) begin
            err_cnt++;
            $display("FAIL hit_slot2: got hit=%b idx=%0d new=%b ev=%b count=%0d valid=%b data=%h, required hit=1 idx=2 new=0 ev=0 count=3 valid=0111 data=%h",
                     hit_out, hit_idx_out, new_out, evict_valid_out, count_out, out_valid, out_data, exp_data);
        end
        // Back-to-back repeat is checked against the window updated by the previous hit.
        drive_sample(8'h11);
        vec_cnt++;
        if ({hit_out, hit_idx_out, out_data} !== {1'b1, exp_idx2, exp_data}) begin
            err_cnt++;
            $display("FAIL hit_back_to_back: got hit=%b idx=%0d data=%h, required hit=1 idx=%0d data=%h",
                     hit_out, hit_idx_out, out_data, exp_idx2, exp_data);
        end
        idle_cycle();
        vec_cnt++;
        if ({hit_out, hit_idx_out} !== {1'b0, 2'd0}) begin
            err_cnt++;
            $display("FAIL hit_pulse_drop: got hit=%b idx=%0d, required hit=0 idx=0",
                     hit_out, hit_idx_out);
        end
    endtask

    task automatic test_clear();
        @(negedge clk_in);
        clear_in = 1'b1;
        in_valid = 1'b1;
        data_in  = 8'h77;
        @(posedge clk_in);
        #1;
        clear_in = 1'b0;
        in_valid = 1'b0;
        vec_cnt++;
        if ({out_valid, count_out, new_out, hit_out, out_data} !== {4'b0000, 3'd0, 1'b0, 1'b0, 32'h0}) begin
            err_cnt++;
            $display("FAIL clear_priority: got valid=%b count=%0d new=%b hit=%b data=%h, required valid=0000 count=0 new=0 hit=0 data=00000000",
                     out_valid, count_out, new_out, hit_out, out_data);
        end
    endtask

    task automatic test_idle();
        drive_sample(8'h01);
        drive_sample(8'h02);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            in_valid = 1'b0;
            data_in  = (i % 2 == 0) ? 8'hAA : 8'hBB;
            @(posedge clk_in);
            #1;
            vec_cnt++;
            if ({out_data, out_valid, count_out, new_out, hit_out, evict_valid_out} !==
                {32'h00000102, 4'b0011, 3'd2, 1'b0, 1'b0, 1'b0}) begin
                err_cnt++;
                $display("FAIL idle_hold[%0d]: got data=%h valid=%b count=%0d new=%b hit=%b ev=%b, required data=00000102 valid=0011 count=2 pulses 0",
                         i, out_data, out_valid, count_out, new_out, hit_out, evict_valid_out);
            end
        end
    endtask

    task automatic test_async_reset();
        drive_sample(8'h03);
        @(posedge clk_in);
        #3;
        reset_n_in = 1'b0;
        #1;
        vec_cnt++;
        if ({out_data, out_valid, count_out, new_out, hit_out, evict_valid_out} !== '0) begin
            err_cnt++;
            $display("FAIL async_reset: got data=%h valid=%b count=%0d new=%b, required all 0 before next edge",
                     out_data, out_valid, count_out, new_out);
        end
        @(negedge clk_in);
        reset_n_in = 1'b1;
        drive_sample(8'h99);
        vec_cnt++;
        if ({new_out, hit_out, out_valid, count_out, out_data} !== {1'b1, 1'b0, 4'b0001, 3'd1, 32'h00000099}) begin
            err_cnt++;
            $display("FAIL resume_after_reset: got new=%b hit=%b valid=%b count=%0d data=%h, required new=1 hit=0 valid=0001 count=1 data=00000099",
                     new_out, hit_out, out_valid, count_out, out_data);
        end
    endtask

    // Sequence and report
    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_zero_insert();
        test_fill_evict();
        test_hit();
        test_clear();
        test_idle();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
